// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h00000013;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding {pc, instruction} pairs between fetch and dispatch.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 52
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, one-outstanding memory requests, and a
// small {pc, instruction} buffer presented to dispatch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int RESET_PC     = 0,
  parameter int DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  output logic                    fetch_read,
  output logic [ADDRESS_BITS-1:0] fetch_address,
  input  logic                    fetch_valid,
  input  logic [DATA_WIDTH-1:0]   fetch_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [ADDRESS_BITS-1:0] out_pc,
  input  logic                    report,
  output logic [1:0]              debug_state,
  output logic                    debug_error,
  output logic [7:0]              debug_core
);

  // Handshake: dispatch takes the head on any cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDRESS_BITS + DATA_WIDTH;
  localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(INSTR_BYTES);

  fetch_state_t            state, state_next;
  logic [ADDRESS_BITS-1:0] pc, pc_next;
  logic                    kill, kill_next;
  logic                    push, pop, flush;
  logic [CW-1:0]           count;
  logic [EW-1:0]           head;
  logic                    protocol_error;
  logic [ADDRESS_BITS-1:0] target;

  assign target = redirect_pc & ~ADDRESS_BITS'(INSTR_BYTES - 1);

  assign fetch_read    = (state == REQ) && (count < CW'(DEPTH)) && !redirect_valid;
  assign fetch_address = pc;
  assign out_valid     = (count != '0) && !redirect_valid;
  assign pop           = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pc             <= ADDRESS_BITS'(RESET_PC);
      kill           <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      kill  <= kill_next;
      if (fetch_valid && (state != WAIT)) begin
        protocol_error <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_next = target;
        end else if (fetch_read) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_next = target;
          // A response landing with the redirect is dropped here, so no kill is needed.
          if (fetch_valid) begin
            state_next = REQ;
            kill_next  = 1'b0;
          end else begin
            kill_next = 1'b1;
          end
        end else if (fetch_valid) begin
          state_next = REQ;
          kill_next  = 1'b0;
          if (!kill) begin
            push    = 1'b1;
            pc_next = pc + STEP;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({pc, fetch_data}),
    .count     (count),
    .head_data (head)
  );

  assign out_pc          = head[EW-1:DATA_WIDTH];
  assign out_instruction = head[DATA_WIDTH-1:0];

  assign debug_state = state;
  assign debug_error = report && protocol_error;
  assign debug_core  = 8'(CORE);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timeline checks, a redirect table, and a
// randomized run against a queue-based reference model with a latency-driven memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock, reset, start, redirect_valid, fetch_valid, out_ready, report;
  logic [19:0] redirect_pc, fetch_address, out_pc;
  logic [31:0] fetch_data, out_instruction;
  logic        fetch_read, out_valid, debug_error;
  logic [1:0]  debug_state;
  logic [7:0]  debug_core;

  fetch_unit #(
    .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .RESET_PC(0), .DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_read(fetch_read), .fetch_address(fetch_address),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .report(report), .debug_state(debug_state),
    .debug_error(debug_error), .debug_core(debug_core)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  // reference model: started flag, outstanding request, kill, pc, buffer contents
  bit          m_busy, m_wait, m_kill;
  logic [19:0] m_pc;
  logic [51:0] exp_q[$];

  // memory environment
  int          mem_cnt = -1;
  logic [19:0] mem_addr;
  int          lat = 1;
  bit          rand_lat = 0;

  // per-cycle samples
  logic        s_read, s_valid;
  logic [19:0] s_addr, s_pc;
  logic [31:0] s_instr;

  typedef struct {
    logic [19:0] rpc;
    logic [19:0] exp_addr;
  } redir_vec_t;

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return (a == 20'h0) ? 32'h00100093 : {12'hA5C, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_kill = 0; m_pc = 20'h0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at negedge, compare with the model, update at posedge.
  task automatic step(input bit rv, input logic [19:0] rpc, input bit rdy, input bit st);
    bit          e_read, e_valid, fv, popped;
    logic [31:0] fd;
    logic [51:0] head;
    @(negedge clock);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    start          = st;
    fv             = (mem_cnt == 0);
    fd             = fv ? mem_word(mem_addr) : 32'($urandom);
    fetch_valid    = fv;
    fetch_data     = fd;
    #1;
    s_read = fetch_read; s_addr = fetch_address; s_valid = out_valid;
    s_pc = out_pc; s_instr = out_instruction;
    e_read  = m_busy && !m_wait && (exp_q.size() < 4) && !rv;
    e_valid = (exp_q.size() != 0) && !rv;
    check("fetch_read", s_read, e_read);
    if (e_read) check("fetch_address", s_addr, m_pc);
    check("out_valid", s_valid, e_valid);
    if (e_valid) begin
      head = exp_q[0];
      check("out_pc", s_pc, head[51:32]);
      check("out_instruction", s_instr, head[31:0]);
    end else if (exp_q.size() == 0) begin
      check("empty_pc", s_pc, 0);
      check("empty_instruction", s_instr, 0);
    end
    popped = e_valid && rdy;
    @(posedge clock);
    if (!m_busy) begin
      if (st) m_busy = 1;
    end else if (rv) begin
      exp_q.delete();
      m_pc = rpc & 20'hFFFFC;
      if (m_wait) begin
        if (fv) begin m_wait = 0; m_kill = 0; end
        else m_kill = 1;
      end
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (m_wait && fv) begin
        if (!m_kill) begin
          exp_q.push_back({m_pc, fd});
          m_pc = m_pc + 20'd4;
        end
        m_kill = 0;
        m_wait = 0;
      end else if (e_read) begin
        m_wait = 1;
      end
    end
    if (fv) mem_cnt = -1;
    else if (mem_cnt > 0) mem_cnt--;
    if (s_read) begin
      mem_addr = s_addr;
      mem_cnt  = (rand_lat ? int'($urandom_range(1, 3)) : lat) - 1;
    end
  endtask

  task automatic wait_read(input bit rdy);
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 20'h0, rdy, 0);
      found = s_read;
    end
    check("wait_read_timeout", found, 1);
  endtask

  redir_vec_t vecs[4];

  initial begin
    reset = 1'b0; start = 0; redirect_valid = 0; redirect_pc = 0;
    fetch_valid = 0; fetch_data = 0; out_ready = 0; report = 0;
    model_reset();
    #2;
    check("rst_fetch_read", fetch_read, 0);
    check("rst_fetch_address", fetch_address, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instruction", out_instruction, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_state", debug_state, IDLE);
    @(negedge clock);
    reset = 1'b1;

    // first fetch with single-cycle memory
    lat = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("c1_read", s_read, 1);
    check("c1_addr", s_addr, 20'h0);
    step(0, 0, 0, 0);
    check("c2_valid", s_valid, 0);
    step(0, 0, 0, 0);
    check("c3_valid", s_valid, 1);
    check("c3_pc", s_pc, 20'h0);
    check("c3_instr", s_instr, 32'h00100093);

    // fill the buffer with dispatch stalled, then release one entry
    for (int i = 4; i < 12; i++) step(0, 0, 0, 0);
    check("full_read", s_read, 0);
    check("full_head_pc", s_pc, 20'h0);
    step(0, 0, 1, 0);
    lat = 3;
    step(0, 0, 0, 0);
    check("after_pop_read", s_read, 1);
    check("after_pop_addr", s_addr, 20'd16);

    // redirect while a response is outstanding; stale data arrives two cycles later
    step(1, 20'h00104, 0, 0);
    step(0, 0, 0, 0);
    lat = 1;
    step(0, 0, 0, 0);
    check("stale_cycle_read", s_read, 0);
    step(0, 0, 0, 0);
    check("redir_read", s_read, 1);
    check("redir_addr", s_addr, 20'h00104);
    check("redir_empty", s_valid, 0);

    // redirect in the same cycle as the response
    step(1, 20'h00200, 0, 0);
    step(0, 0, 0, 0);
    check("coinc_read", s_read, 1);
    check("coinc_addr", s_addr, 20'h00200);
    check("coinc_empty", s_valid, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("coinc_nokill_valid", s_valid, 1);
    check("coinc_nokill_pc", s_pc, 20'h00200);
    check("coinc_nokill_instr", s_instr, 32'hA5C00200);

    // redirect target alignment table
    vecs[0] = '{rpc: 20'h00107, exp_addr: 20'h00104};
    vecs[1] = '{rpc: 20'hFFFFF, exp_addr: 20'hFFFFC};
    vecs[2] = '{rpc: 20'h12346, exp_addr: 20'h12344};
    vecs[3] = '{rpc: 20'h00003, exp_addr: 20'h00000};
    for (int v = 0; v < 4; v++) begin
      step(1, vecs[v].rpc, 1, 0);
      wait_read(1);
      check("table_addr", s_addr, vecs[v].exp_addr);
    end

    // wrap at the top of the address space
    step(1, 20'hFFFFD, 1, 0);
    wait_read(1);
    check("wrap_first", s_addr, 20'hFFFFC);
    wait_read(1);
    check("wrap_next", s_addr, 20'h00000);

    // randomized traffic against the model
    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 15) == 0), 20'($urandom), ($urandom_range(0, 3) != 0), 0);
    end
    rand_lat = 0;

    // build up two entries with a request outstanding, then reset asynchronously
    lat = 3;
    begin
      bit reached = 0;
      step(1, 20'h00040, 0, 0);
      for (int i = 0; i < 60 && !reached; i++) begin
        step(0, 0, 0, 0);
        reached = (exp_q.size() == 2) && m_wait && (mem_cnt >= 0);
      end
      check("reach_wait_count2", reached, 1);
    end
    @(negedge clock);
    redirect_valid = 0;
    fetch_valid    = 0;
    report         = 1;
    #2;
    check("pre_reset_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("async_fetch_read", fetch_read, 0);
    check("async_fetch_address", fetch_address, 0);
    check("async_out_valid", out_valid, 0);
    check("async_out_pc", out_pc, 0);
    check("async_out_instruction", out_instruction, 0);
    check("async_state", debug_state, IDLE);
    check("async_error_clear", debug_error, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    check("late_resp_state", debug_state, IDLE);
    check("late_resp_flagged", debug_error, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
